// File: rtl/sbr_chain_builder.sv
// SBR chain builder: folds each finished SRR descriptor into its per-bank SBR entry,
// allocating a new entry on a CAM miss and read-modify-writing totals/tail (with an SRR link) on a hit.
module sbr_chain_builder #(
    parameter int SBR_ID_W = 4,
    parameter int SRR_ID_W = 6,
    parameter int REQ_W    = 8,
    parameter int BG_W     = 2,
    parameter int BANK_W   = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [SRR_ID_W-1:0]    in_srr_id,
    input  logic [BG_W-1:0]        in_bank_group,
    input  logic [BANK_W-1:0]      in_bank,
    input  logic [REQ_W-1:0]       in_req_count,
    input  logic                   in_last,
    output logic                   tbl_clear,
    output logic                   tbl_cam_en,
    output logic [BG_W+BANK_W-1:0] tbl_cam_tag,
    input  logic                   tbl_cam_hit,
    input  logic [SBR_ID_W-1:0]    tbl_cam_addr,
    output logic                   tbl_wr_en,
    output logic [BG_W+BANK_W-1:0] tbl_wr_tag,
    output logic [BG_W-1:0]        tbl_wr_bg,
    output logic [BANK_W-1:0]      tbl_wr_bank,
    output logic [SRR_ID_W-1:0]    tbl_wr_head,
    input  logic                   tbl_full,
    input  logic [SBR_ID_W-1:0]    tbl_wr_addr,
    output logic                   tbl_upd_en,
    output logic [SBR_ID_W-1:0]    tbl_upd_addr,
    output logic [REQ_W-1:0]       tbl_upd_total,
    output logic [SRR_ID_W-1:0]    tbl_upd_rows,
    output logic [SRR_ID_W-1:0]    tbl_upd_tail,
    output logic [SBR_ID_W-1:0]    tbl_rd_addr,
    input  logic [REQ_W-1:0]       tbl_rd_total,
    input  logic [SRR_ID_W-1:0]    tbl_rd_rows,
    input  logic [SRR_ID_W-1:0]    tbl_rd_tail,
    output logic                   link_en,
    output logic [SRR_ID_W-1:0]    link_from,
    output logic [SRR_ID_W-1:0]    link_to,
    output logic                   build_done,
    output logic                   busy,
    output logic [7:0]             drop_cnt,
    output logic                   err_overflow,
    output logic [2:0]             fsm_state
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOOKUP = 3'd1;
    localparam logic [2:0] S_NEW    = 3'd2;
    localparam logic [2:0] S_READ   = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    logic [2:0]          state;
    logic [2:0]          state_next;
    logic [SRR_ID_W-1:0] srr_id;
    logic [BG_W-1:0]     bg;
    logic [BANK_W-1:0]   bank;
    logic [REQ_W-1:0]    req_count;
    logic                last;
    logic [SBR_ID_W-1:0] hit_addr;
    logic                accept;
    logic                drop;
    logic                item_done;
    logic [REQ_W:0]      total_sum;
    logic [SRR_ID_W:0]   rows_sum;
    logic [REQ_W-1:0]    total_sat;
    logic [SRR_ID_W-1:0] rows_sat;

    // Handshake: a descriptor transfers on a rising edge where in_valid && in_ready;
    // in_ready is high only in IDLE without clear, so at most one item is in flight.
    assign in_ready  = (state == S_IDLE) && !clear;
    assign accept    = in_valid && in_ready;
    assign drop      = (state == S_LOOKUP) && !tbl_cam_hit && tbl_full && !clear;
    assign item_done = !clear && ((state == S_NEW) || (state == S_UPDATE) || drop);
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;
    assign tbl_clear = clear;

    assign total_sum = {1'b0, tbl_rd_total} + {1'b0, req_count};
    assign rows_sum  = {1'b0, tbl_rd_rows} + {{SRR_ID_W{1'b0}}, 1'b1};
    assign total_sat = total_sum[REQ_W]    ? {REQ_W{1'b1}}    : total_sum[REQ_W-1:0];
    assign rows_sat  = rows_sum[SRR_ID_W]  ? {SRR_ID_W{1'b1}} : rows_sum[SRR_ID_W-1:0];

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:   if (accept) state_next = S_LOOKUP;
            S_LOOKUP: begin
                if (tbl_cam_hit)    state_next = S_READ;
                else if (!tbl_full) state_next = S_NEW;
                else                state_next = S_IDLE;
            end
            S_NEW:    state_next = S_IDLE;
            S_READ:   state_next = S_UPDATE;
            S_UPDATE: state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (clear) state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srr_id    <= '0;
            bg        <= '0;
            bank      <= '0;
            req_count <= '0;
            last      <= 1'b0;
        end else if (clear) begin
            last      <= 1'b0;
        end else if (accept) begin
            srr_id    <= in_srr_id;
            bg        <= in_bank_group;
            bank      <= in_bank;
            req_count <= in_req_count;
            last      <= in_last;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_addr <= '0;
        end else if ((state == S_LOOKUP) && tbl_cam_hit && !clear) begin
            hit_addr <= tbl_cam_addr;
        end
    end

    // Drop accounting and the done pulse; clear wipes both and suppresses the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_cnt     <= 8'd0;
            err_overflow <= 1'b0;
            build_done   <= 1'b0;
        end else if (clear) begin
            drop_cnt     <= 8'd0;
            err_overflow <= 1'b0;
            build_done   <= 1'b0;
        end else begin
            if (drop) begin
                err_overflow <= 1'b1;
                if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
            end
            build_done <= item_done && last;
        end
    end

    assign tbl_cam_tag = {bg, bank};
    assign tbl_wr_tag  = {bg, bank};
    assign tbl_wr_bg   = bg;
    assign tbl_wr_bank = bank;
    assign tbl_wr_head = srr_id;
    assign tbl_rd_addr = (state == S_LOOKUP) ? tbl_cam_addr : hit_addr;

    always_comb begin
        tbl_cam_en    = 1'b0;
        tbl_wr_en     = 1'b0;
        tbl_upd_en    = 1'b0;
        tbl_upd_addr  = '0;
        tbl_upd_total = '0;
        tbl_upd_rows  = '0;
        tbl_upd_tail  = '0;
        link_en       = 1'b0;
        link_from     = '0;
        link_to       = '0;
        if (!clear) begin
            case (state)
                S_LOOKUP: begin
                    tbl_cam_en = 1'b1;
                    tbl_wr_en  = !tbl_cam_hit && !tbl_full;
                end
                S_NEW: begin
                    tbl_upd_en    = 1'b1;
                    tbl_upd_addr  = tbl_wr_addr;
                    tbl_upd_total = req_count;
                    tbl_upd_rows  = {{(SRR_ID_W-1){1'b0}}, 1'b1};
                    tbl_upd_tail  = srr_id;
                end
                S_UPDATE: begin
                    tbl_upd_en    = 1'b1;
                    tbl_upd_addr  = hit_addr;
                    tbl_upd_total = total_sat;
                    tbl_upd_rows  = rows_sat;
                    tbl_upd_tail  = srr_id;
                    link_en       = 1'b1;
                    link_from     = tbl_rd_tail;
                    link_to       = srr_id;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sbr_chain_builder.sv
// Bench for sbr_chain_builder: a behavioural SBR table sits around the DUT, and a tag-keyed
// reference model predicts every update, link, drop and done pulse.
module tb_sbr_chain_builder;

  localparam int TAG_W = 5;

  logic       clk;
  logic       rst_n;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [5:0] in_srr_id;
  logic [2:0] in_bank_group;
  logic [1:0] in_bank;
  logic [7:0] in_req_count;
  logic       in_last;
  logic       tbl_clear;
  logic       tbl_cam_en;
  logic [TAG_W-1:0] tbl_cam_tag;
  logic       tbl_cam_hit;
  logic [3:0] tbl_cam_addr;
  logic       tbl_wr_en;
  logic [TAG_W-1:0] tbl_wr_tag;
  logic [2:0] tbl_wr_bg;
  logic [1:0] tbl_wr_bank;
  logic [5:0] tbl_wr_head;
  logic       tbl_full;
  logic [3:0] tbl_wr_addr;
  logic       tbl_upd_en;
  logic [3:0] tbl_upd_addr;
  logic [7:0] tbl_upd_total;
  logic [5:0] tbl_upd_rows;
  logic [5:0] tbl_upd_tail;
  logic [3:0] tbl_rd_addr;
  logic [7:0] tbl_rd_total;
  logic [5:0] tbl_rd_rows;
  logic [5:0] tbl_rd_tail;
  logic       link_en;
  logic [5:0] link_from;
  logic [5:0] link_to;
  logic       build_done;
  logic       busy;
  logic [7:0] drop_cnt;
  logic       err_overflow;
  logic [2:0] fsm_state;

  int n_cmp = 0;
  int n_err = 0;

  sbr_chain_builder #(
    .SBR_ID_W(4), .SRR_ID_W(6), .REQ_W(8), .BG_W(3), .BANK_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .in_srr_id(in_srr_id),
    .in_bank_group(in_bank_group), .in_bank(in_bank), .in_req_count(in_req_count),
    .in_last(in_last), .tbl_clear(tbl_clear), .tbl_cam_en(tbl_cam_en),
    .tbl_cam_tag(tbl_cam_tag), .tbl_cam_hit(tbl_cam_hit), .tbl_cam_addr(tbl_cam_addr),
    .tbl_wr_en(tbl_wr_en), .tbl_wr_tag(tbl_wr_tag), .tbl_wr_bg(tbl_wr_bg),
    .tbl_wr_bank(tbl_wr_bank), .tbl_wr_head(tbl_wr_head), .tbl_full(tbl_full),
    .tbl_wr_addr(tbl_wr_addr), .tbl_upd_en(tbl_upd_en), .tbl_upd_addr(tbl_upd_addr),
    .tbl_upd_total(tbl_upd_total), .tbl_upd_rows(tbl_upd_rows), .tbl_upd_tail(tbl_upd_tail),
    .tbl_rd_addr(tbl_rd_addr), .tbl_rd_total(tbl_rd_total), .tbl_rd_rows(tbl_rd_rows),
    .tbl_rd_tail(tbl_rd_tail), .link_en(link_en), .link_from(link_from), .link_to(link_to),
    .build_done(build_done), .busy(busy), .drop_cnt(drop_cnt),
    .err_overflow(err_overflow), .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached with %0d compared", n_cmp);
    $fatal(1, "simulation time limit");
  end

  // ---------------- behavioural SBR table ----------------
  logic [TAG_W-1:0] e_tag   [16];
  logic             e_valid [16];
  logic [7:0]       e_total [16];
  logic [5:0]       e_rows  [16];
  logic [5:0]       e_tail  [16];
  logic [4:0]       e_cnt;

  assign tbl_full = e_cnt[4];

  always @* begin
    tbl_cam_hit  = 1'b0;
    tbl_cam_addr = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (e_valid[i] && e_tag[i] == tbl_cam_tag) begin
        tbl_cam_hit  = 1'b1;
        tbl_cam_addr = 4'(i);
      end
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_cnt        <= 5'd0;
      tbl_wr_addr  <= 4'd0;
      tbl_rd_total <= 8'd0;
      tbl_rd_rows  <= 6'd0;
      tbl_rd_tail  <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        e_valid[i] <= 1'b0;
        e_tag[i]   <= '0;
        e_total[i] <= 8'd0;
        e_rows[i]  <= 6'd0;
        e_tail[i]  <= 6'd0;
      end
    end else if (tbl_clear) begin
      e_cnt <= 5'd0;
      for (int i = 0; i < 16; i++) e_valid[i] <= 1'b0;
    end else begin
      if (tbl_wr_en && !e_cnt[4]) begin
        e_valid[e_cnt[3:0]] <= 1'b1;
        e_tag[e_cnt[3:0]]   <= tbl_wr_tag;
        tbl_wr_addr         <= e_cnt[3:0];
        e_cnt               <= e_cnt + 5'd1;
      end
      if (tbl_upd_en) begin
        e_total[tbl_upd_addr] <= tbl_upd_total;
        e_rows[tbl_upd_addr]  <= tbl_upd_rows;
        e_tail[tbl_upd_addr]  <= tbl_upd_tail;
      end
      tbl_rd_total <= e_total[tbl_rd_addr];
      tbl_rd_rows  <= e_rows[tbl_rd_addr];
      tbl_rd_tail  <= e_tail[tbl_rd_addr];
    end
  end

  // ---------------- reference model ----------------
  logic [23:0] exp_upd  [$];   // {addr, total, rows, tail}
  logic [11:0] exp_link [$];   // {from, to}
  logic       m_valid [32];
  logic [3:0] m_addr  [32];
  int         m_total [32];
  int         m_rows  [32];
  logic [5:0] m_tail  [32];
  int         m_count;
  int         m_drops;
  int         exp_done = 0;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
    m_count = 0;
    m_drops = 0;
  endfunction

  // Returns 0 for a new entry, 1 for a chained hit, 2 for a drop.
  function automatic int model_push(input logic [5:0] srr, input logic [TAG_W-1:0] tag,
                                    input logic [7:0] cnt, input logic lst);
    int k;
    if (lst) exp_done++;
    if (m_valid[tag]) begin
      k = 1;
      m_total[tag] = (m_total[tag] + int'(cnt) > 255) ? 255 : m_total[tag] + int'(cnt);
      m_rows[tag]  = (m_rows[tag] >= 63) ? 63 : m_rows[tag] + 1;
      exp_link.push_back({m_tail[tag], srr});
      m_tail[tag]  = srr;
      exp_upd.push_back({m_addr[tag], 8'(m_total[tag]), 6'(m_rows[tag]), srr});
    end else if (m_count < 16) begin
      k = 0;
      m_valid[tag] = 1'b1;
      m_addr[tag]  = 4'(m_count);
      m_count++;
      m_total[tag] = int'(cnt);
      m_rows[tag]  = 1;
      m_tail[tag]  = srr;
      exp_upd.push_back({m_addr[tag], cnt, 6'd1, srr});
    end else begin
      k = 2;
      if (m_drops < 255) m_drops++;
    end
    return k;
  endfunction

  // ---------------- scoreboard / monitor ----------------
  int          n_upd  = 0;
  int          n_link = 0;
  int          n_wr   = 0;
  int          n_done = 0;
  logic [23:0] last_upd;
  logic [11:0] last_link;
  logic [23:0] mon_upd, mon_eu;
  logic [11:0] mon_link, mon_el;

  always @(negedge clk) begin
    if (rst_n) begin
      if (tbl_upd_en) begin
        mon_upd = {tbl_upd_addr, tbl_upd_total, tbl_upd_rows, tbl_upd_tail};
        last_upd = mon_upd;
        n_upd++;
        n_cmp++;
        if (exp_upd.size() == 0) begin
          n_err++;
          $display("FAIL upd_unexpected: got %h, expected no update", mon_upd);
        end else begin
          mon_eu = exp_upd.pop_front();
          if (mon_upd !== mon_eu) begin
            n_err++;
            $display("FAIL upd_fields: got %h, expected %h", mon_upd, mon_eu);
          end
        end
      end
      if (link_en) begin
        mon_link = {link_from, link_to};
        last_link = mon_link;
        n_link++;
        n_cmp++;
        if (exp_link.size() == 0) begin
          n_err++;
          $display("FAIL link_unexpected: got %h, expected no link", mon_link);
        end else begin
          mon_el = exp_link.pop_front();
          if (mon_link !== mon_el) begin
            n_err++;
            $display("FAIL link_fields: got %h, expected %h", mon_link, mon_el);
          end
        end
      end
      if (tbl_wr_en) n_wr++;
      if (build_done) n_done++;
    end
  end

  // ---------------- driver ----------------
  task automatic send_desc(input logic [5:0] srr, input logic [TAG_W-1:0] tag,
                           input logic [7:0] cnt, input logic lst);
    int t;
    void'(model_push(srr, tag, cnt, lst));
    @(negedge clk);
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL send_ready: in_ready %b after %0d cycles, expected 1", in_ready, t);
    end
    in_valid      = 1'b1;
    in_srr_id     = srr;
    in_bank_group = tag[4:2];
    in_bank       = tag[1:0];
    in_req_count  = cnt;
    in_last       = lst;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    t = 0;
    while (busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_err++;
      $display("FAIL send_idle: busy %b after %0d cycles, expected 0", busy, t);
    end
    @(negedge clk);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, tbl_upd_en, link_en, build_done} !== 4'b0) begin
      n_err++;
      $display("FAIL reset_hold: busy/upd/link/done %b, expected 0000",
               {busy, tbl_upd_en, link_en, build_done});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ready: got %b, expected 1", in_ready);
    end
    n_cmp++;
    if ({tbl_cam_en, tbl_wr_en, tbl_upd_en, link_en, build_done, busy} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_strobes: got %b, expected 000000",
               {tbl_cam_en, tbl_wr_en, tbl_upd_en, link_en, build_done, busy});
    end
    n_cmp++;
    if ({drop_cnt, err_overflow} !== 9'd0) begin
      n_err++;
      $display("FAIL reset_counters: drop %0d err %b, expected 0 0", drop_cnt, err_overflow);
    end
    n_cmp++;
    if ({tbl_upd_total, tbl_upd_tail, link_from, link_to, tbl_wr_head} !== 32'd0) begin
      n_err++;
      $display("FAIL reset_data: got %h, expected 0",
               {tbl_upd_total, tbl_upd_tail, link_from, link_to, tbl_wr_head});
    end
  endtask

  task automatic test_first_miss();
    void'(model_push(6'd5, 5'b001_10, 8'd3, 1'b1));
    @(negedge clk);
    in_valid      = 1'b1;
    in_srr_id     = 6'd5;
    in_bank_group = 3'd1;
    in_bank       = 2'd2;
    in_req_count  = 8'd3;
    in_last       = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    n_cmp++;
    if ({tbl_cam_en, tbl_wr_en, tbl_wr_head, tbl_cam_tag, in_ready} !== {1'b1, 1'b1, 6'd5, 5'b001_10, 1'b0}) begin
      n_err++;
      $display("FAIL miss_lookup: cam/wr/head/tag/ready %b %b %0d %b %b, expected 1 1 5 00110 0",
               tbl_cam_en, tbl_wr_en, tbl_wr_head, tbl_cam_tag, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({tbl_upd_en, tbl_upd_total, tbl_upd_rows, tbl_upd_tail, link_en} !== {1'b1, 8'd3, 6'd1, 6'd5, 1'b0}) begin
      n_err++;
      $display("FAIL miss_update: en %b total %0d rows %0d tail %0d link %b, expected 1 3 1 5 0",
               tbl_upd_en, tbl_upd_total, tbl_upd_rows, tbl_upd_tail, link_en);
    end
    @(negedge clk);
    n_cmp++;
    if ({build_done, in_ready} !== 2'b11) begin
      n_err++;
      $display("FAIL miss_done: done %b ready %b, expected 1 1", build_done, in_ready);
    end
    @(negedge clk);
    n_cmp++;
    if ({build_done, n_link} !== {1'b0, 32'd0}) begin
      n_err++;
      $display("FAIL miss_after: done %b links %0d, expected 0 0", build_done, n_link);
    end
  endtask

  task automatic test_hit_chain();
    int link_b;
    link_b = n_link;
    send_desc(6'd9, 5'b001_10, 8'd4, 1'b0);
    n_cmp++;
    if (last_upd !== {4'd0, 8'd7, 6'd2, 6'd9}) begin
      n_err++;
      $display("FAIL hit_update: got %h, expected %h", last_upd, {4'd0, 8'd7, 6'd2, 6'd9});
    end
    n_cmp++;
    if (n_link != link_b + 1 || last_link !== {6'd5, 6'd9}) begin
      n_err++;
      $display("FAIL hit_link: count %0d link %h, expected %0d %h", n_link, last_link, link_b + 1, {6'd5, 6'd9});
    end
  endtask

  task automatic test_saturation();
    send_desc(6'd10, 5'b010_00, 8'd200, 1'b0);
    send_desc(6'd11, 5'b010_00, 8'd50, 1'b0);
    n_cmp++;
    if (last_upd[19:12] !== 8'd250) begin
      n_err++;
      $display("FAIL sat_total_pre: got %0d, expected 250", last_upd[19:12]);
    end
    send_desc(6'd12, 5'b010_00, 8'd10, 1'b0);
    n_cmp++;
    if (last_upd[19:12] !== 8'd255) begin
      n_err++;
      $display("FAIL sat_total: got %0d, expected 255", last_upd[19:12]);
    end
    for (int i = 0; i < 64; i++) send_desc(6'(i), 5'b010_01, 8'd1, 1'b0);
    n_cmp++;
    if ({last_upd[19:12], last_upd[11:6]} !== {8'd64, 6'd63}) begin
      n_err++;
      $display("FAIL sat_rows: total %0d rows %0d, expected 64 63", last_upd[19:12], last_upd[11:6]);
    end
  endtask

  task automatic test_table_full();
    int wr_b, upd_b, done_b, spare;
    spare = -1;
    for (int t = 0; t < 32; t++) begin
      if (!m_valid[t] && m_count < 16) send_desc(6'(20 + t), 5'(t), 8'(t + 1), 1'b0);
      else if (!m_valid[t]) spare = t;
    end
    wr_b   = n_wr;
    done_b = n_done;
    send_desc(6'd50, 5'(spare), 8'd2, 1'b1);
    n_cmp++;
    if (n_wr != wr_b) begin
      n_err++;
      $display("FAIL full_no_write: writes %0d, expected %0d", n_wr, wr_b);
    end
    n_cmp++;
    if ({drop_cnt, err_overflow} !== {8'd1, 1'b1}) begin
      n_err++;
      $display("FAIL full_drop: drop %0d err %b, expected 1 1", drop_cnt, err_overflow);
    end
    n_cmp++;
    if (n_done != done_b + 1) begin
      n_err++;
      $display("FAIL full_done: dones %0d, expected %0d", n_done, done_b + 1);
    end
    upd_b = n_upd;
    send_desc(6'd60, 5'b001_10, 8'd1, 1'b0);
    n_cmp++;
    if (n_upd != upd_b + 1 || last_upd !== {4'd0, 8'd8, 6'd3, 6'd60}) begin
      n_err++;
      $display("FAIL full_hit: updates %0d last %h, expected %0d %h",
               n_upd, last_upd, upd_b + 1, {4'd0, 8'd8, 6'd3, 6'd60});
    end
  endtask

  task automatic test_clear_mid();
    int upd_b, link_b, done_b;
    upd_b  = n_upd;
    link_b = n_link;
    done_b = n_done;
    @(negedge clk);
    n_cmp++;
    if (drop_cnt !== 8'(m_drops)) begin
      n_err++;
      $display("FAIL clear_pre_drop: got %0d, expected %0d", drop_cnt, m_drops);
    end
    in_valid      = 1'b1;
    in_srr_id     = 6'd33;
    in_bank_group = 3'd1;
    in_bank       = 2'd2;
    in_req_count  = 8'd1;
    in_last       = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, tbl_rd_addr, tbl_upd_en} !== {1'b1, 4'd0, 1'b0}) begin
      n_err++;
      $display("FAIL clear_read_phase: busy %b rd_addr %0d upd %b, expected 1 0 0", busy, tbl_rd_addr, tbl_upd_en);
    end
    clear = 1'b1;
    #1;
    n_cmp++;
    if ({tbl_clear, in_ready, tbl_cam_en, tbl_wr_en, tbl_upd_en, link_en} !== 6'b100000) begin
      n_err++;
      $display("FAIL clear_strobes: clr/ready/cam/wr/upd/link %b, expected 100000",
               {tbl_clear, in_ready, tbl_cam_en, tbl_wr_en, tbl_upd_en, link_en});
    end
    @(negedge clk);
    clear = 1'b0;
    #1;
    n_cmp++;
    if ({busy, drop_cnt, err_overflow, in_ready} !== {1'b0, 8'd0, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL clear_after: busy %b drop %0d err %b ready %b, expected 0 0 0 1",
               busy, drop_cnt, err_overflow, in_ready);
    end
    repeat (4) @(negedge clk);
    n_cmp++;
    if (n_upd != upd_b || n_link != link_b || n_done != done_b) begin
      n_err++;
      $display("FAIL clear_quiet: upd %0d link %0d done %0d, expected %0d %0d %0d",
               n_upd, n_link, n_done, upd_b, link_b, done_b);
    end
    model_reset();
  endtask

  task automatic test_back_to_back();
    logic [5:0]       s  [3];
    logic [TAG_W-1:0] tg [3];
    logic [7:0]       c  [3];
    int k [3];
    int idx, lows, t, exp_lows, upd_b, link_b;
    logic acc;
    s  = '{6'd40, 6'd41, 6'd42};
    tg = '{5'b011_11, 5'b011_11, 5'b100_01};
    c  = '{8'd5, 8'd6, 8'd7};
    for (int i = 0; i < 3; i++) k[i] = model_push(s[i], tg[i], c[i], i == 2);
    exp_lows = 0;
    for (int i = 0; i < 2; i++) exp_lows += (k[i] == 1) ? 3 : (k[i] == 0) ? 2 : 1;
    upd_b  = n_upd;
    link_b = n_link;
    @(negedge clk);
    idx = 0;
    lows = 0;
    t = 0;
    in_valid      = 1'b1;
    in_srr_id     = s[0];
    in_bank_group = tg[0][4:2];
    in_bank       = tg[0][1:0];
    in_req_count  = c[0];
    in_last       = 1'b0;
    while (idx < 3 && t < 60) begin
      acc = in_ready;
      if (!acc) lows++;
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 3) begin
          in_srr_id     = s[idx];
          in_bank_group = tg[idx][4:2];
          in_bank       = tg[idx][1:0];
          in_req_count  = c[idx];
          in_last       = (idx == 2);
        end else begin
          in_valid = 1'b0;
          in_last  = 1'b0;
        end
      end
      @(negedge clk);
      t++;
    end
    t = 0;
    while (busy && t < 10) begin
      @(negedge clk);
      t++;
    end
    @(negedge clk);
    n_cmp++;
    if (idx != 3 || lows != exp_lows) begin
      n_err++;
      $display("FAIL b2b_ready: accepts %0d ready-low cycles %0d, expected 3 %0d", idx, lows, exp_lows);
    end
    n_cmp++;
    if (n_upd != upd_b + 3 || n_link != link_b + 1) begin
      n_err++;
      $display("FAIL b2b_events: updates %0d links %0d, expected %0d %0d", n_upd, n_link, upd_b + 3, link_b + 1);
    end
    n_cmp++;
    if (n_done != exp_done) begin
      n_err++;
      $display("FAIL b2b_done: dones %0d, expected %0d", n_done, exp_done);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      send_desc(6'($urandom_range(0, 63)), 5'($urandom_range(0, 31)),
                8'($urandom_range(1, 255)), $urandom_range(0, 3) == 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    n_cmp++;
    if ({drop_cnt, err_overflow} !== {8'(m_drops), m_drops > 0}) begin
      n_err++;
      $display("FAIL rand_drops: drop %0d err %b, expected %0d %b", drop_cnt, err_overflow, m_drops, m_drops > 0);
    end
    n_cmp++;
    if (n_done != exp_done) begin
      n_err++;
      $display("FAIL rand_done: dones %0d, expected %0d", n_done, exp_done);
    end
  endtask

  initial begin
    model_reset();
    rst_n         = 1'b0;
    clear         = 1'b0;
    in_valid      = 1'b0;
    in_srr_id     = 6'd0;
    in_bank_group = 3'd0;
    in_bank       = 2'd0;
    in_req_count  = 8'd0;
    in_last       = 1'b0;
    test_reset();
    test_first_miss();
    test_hit_chain();
    test_saturation();
    test_table_full();
    test_clear_mid();
    test_back_to_back();
    test_random();
    n_cmp++;
    if (exp_upd.size() != 0 || exp_link.size() != 0) begin
      n_err++;
      $display("FAIL leftover: %0d updates and %0d links never seen, expected 0 0", exp_upd.size(), exp_link.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/sbr_chain_builder.md
# sbr_chain_builder

Upstream feeder of the SBR table. It consumes a stream of finished SRR descriptors (one per same-row group) and folds each one into the per-bank SBR chains. For every descriptor it does a CAM lookup on {bank_group, bank} and then takes one of two paths:
- **Miss:** allocate a new SBR entry.
- **Hit:** read-modify-write the entry's totals and tail, and emit a link command so the SRR table can chain the previous tail to the new SRR.

It signals `build_done` after the last descriptor of a batch, which starts critical-path selection.

## Interface
Parameters:
- `SBR_ID_W`, 4: SBR index width; the table holds 2**SBR_ID_W entries.
- `SRR_ID_W`, 6: SRR index width.
- `REQ_W`, 8: request count width.
- `BG_W`, 2: bank-group width.
- `BANK_W`, 2: bank width. Miss tag = {bank_group, bank}, width BG_W+BANK_W.

Ports:
- `clk`  in  1  clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `clear`  in  1  synchronous flush of builder and table
- `in_valid`  in  1  SRR descriptor valid
- `in_ready`  out  1  builder can accept a descriptor
- `in_srr_id`  in  SRR_ID_W  SRR entry index
- `in_bank_group`  in  BG_W  bank group
- `in_bank`  in  BANK_W  bank
- `in_req_count`  in  REQ_W  requests in this SRR (≥1)
- `in_last`  in  1  last descriptor of batch
- `tbl_clear`  out  1  to table `clear`
- `tbl_cam_en`  out  1  to table CAM lookup enable
- `tbl_cam_tag`  out  BG_W+BANK_W  to table CAM lookup tag
- `tbl_cam_hit`  in  1  from table (combinational)
- `tbl_cam_addr`  in  SBR_ID_W  from table (combinational)
- `tbl_wr_en`  out  1  to table write
- `tbl_wr_tag`  out  BG_W+BANK_W  to table write
- `tbl_wr_bg`  out  BG_W  to table write
- `tbl_wr_bank`  out  BANK_W  to table write
- `tbl_wr_head`  out  SRR_ID_W  to table write
- `tbl_full`  in  1  from table
- `tbl_wr_addr`  in  SBR_ID_W  from table, valid the cycle after `tbl_wr_en`
- `tbl_upd_en`  out  1  to table update
- `tbl_upd_addr`  out  SBR_ID_W  to table update
- `tbl_upd_total`  out  REQ_W  to table update
- `tbl_upd_rows`  out  SRR_ID_W  to table update
- `tbl_upd_tail`  out  SRR_ID_W  to table update
- `tbl_rd_addr`  out  SBR_ID_W  to table read
- `tbl_rd_total`  in  REQ_W  registered table read data, 1-cycle latency
- `tbl_rd_rows`  in  SRR_ID_W  registered table read data, 1-cycle latency
- `tbl_rd_tail`  in  SRR_ID_W  registered table read data, 1-cycle latency
- `link_en`  out  1  SRR next-pointer write strobe
- `link_from`  out  SRR_ID_W  previous tail SRR
- `link_to`  out  SRR_ID_W  new SRR
- `build_done`  out  1  one-cycle pulse after the `in_last` item completes
- `busy`  out  1  state ≠ IDLE
- `drop_cnt`  out  8  descriptors dropped because the table was full
- `err_overflow`  out  1  sticky; set on any drop

## Operation
- **FSM states:** IDLE, LOOKUP, NEW, READ, UPDATE.
- **IDLE:**
  - `in_ready` = 1 (combinational: state==IDLE && !clear).
  - On `in_valid && in_ready`, latch the descriptor fields and `in_last`, then go to LOOKUP.
- **LOOKUP:** assert `tbl_cam_en` with tag = latched {bg, bank}.
  - Hit: drive `tbl_rd_addr` = `tbl_cam_addr`, register it as `hit_addr`, go to READ.
  - Miss and !`tbl_full`: assert `tbl_wr_en` with head = `srr_id`, go to NEW.
  - Miss and `tbl_full`: no table write; `drop_cnt`++ (saturates at 255); set `err_overflow`; go to IDLE (the done rule still applies).
- **NEW:** `tbl_upd_en` = 1 with:
  - addr = `tbl_wr_addr`
  - total = `req_count`
  - rows = 1
  - tail = `srr_id`
  - no link; go to IDLE.
- **READ:** hold `tbl_rd_addr` = `hit_addr`; the registered read data becomes valid at the end of this cycle. Go to UPDATE.
- **UPDATE:** `tbl_upd_en` = 1 with:
  - addr = `hit_addr`
  - total = sat(`tbl_rd_total` + `req_count`) at 2**REQ_W−1
  - rows = sat(`tbl_rd_rows` + 1) at 2**SRR_ID_W−1
  - tail = `srr_id`

  In the same cycle, `link_en` = 1 with `link_from` = `tbl_rd_tail` and `link_to` = `srr_id`. Go to IDLE.
- **Done rule:** `build_done` pulses the cycle after the final state (NEW, UPDATE, or LOOKUP-drop) of an item whose `in_last` was set.
- **Clear:** `tbl_clear` = `clear` (combinational pass-through). Clear has priority over every state:
  - FSM returns to IDLE and the latched item is discarded.
  - `drop_cnt` and `err_overflow` are zeroed; no `build_done`.
  - All table strobes are 0 while `clear` = 1.

## Timing
- **Reset values:**
  - State IDLE.
  - All strobes 0 (`tbl_cam_en`, `tbl_wr_en`, `tbl_upd_en`, `link_en`, `build_done`).
  - All registered data/address outputs 0; `drop_cnt` 0; `err_overflow` 0; `busy` 0.
  - `in_ready` = 1 once `rst_n` is high.
- **Reset mid-operation:** the FSM aborts immediately to IDLE.
- **Occupancy per descriptor (accept edge to return to IDLE):**
  - Miss: 3 cycles (IDLE, LOOKUP, NEW).
  - Hit: 4 cycles (IDLE, LOOKUP, READ, UPDATE).
  - Drop: 2 cycles.
- **`in_ready` timing:** `in_ready` is 0 from the cycle after accept until the state returns to IDLE, so there is no back-to-back acceptance.
- **Hazard-free by construction:** a table update written at the end of NEW/UPDATE is visible to the next item's LOOKUP, which occurs at least 2 cycles later. Two SRRs with the same tag therefore always chain correctly.
- **Strobe width:** all `tbl_*` strobes are single-cycle and derived from the current state.

## Test plan
- **Reset and first miss.** After reset, send SRR 5 (bg1, bank2, count 3, last). Expect:
  - `tbl_wr_en` in cycle 2, then `upd` with total 3, rows 1, tail 5.
  - No `link_en`; `build_done` on the next cycle.
- **Hit chaining.** Send SRR 5 (bg1, bk2, count 3), then SRR 9 (bg1, bk2, count 4). Expect:
  - Second item: `upd` total 7, rows 2, tail 9.
  - `link_en` with `from` = 5, `to` = 9.
- **Saturation.** REQ_W = 8: an entry at total 250 plus `count` 10 yields `upd_total` 255. An entry at rows 63 with SRR_ID_W = 6 stays at 63.
- **Table full.** 16 distinct tags, then a 17th new tag. Expect:
  - No `wr_en`; `drop_cnt` = 1; `err_overflow` = 1.
  - A subsequent hit on an existing tag still updates.
- **Clear mid-operation.** Assert `clear` while in READ. Expect:
  - `tbl_clear` = 1, no `upd`/`link` strobes, state IDLE.
  - `drop_cnt` = 0; `in_ready` = 1 the cycle after `clear` deasserts.
- **Backpressure.** Hold `in_valid` for 3 descriptors. Expect `in_ready` low between accepts, and each descriptor accepted exactly once (3 updates, no duplicates).
